// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode encodings for the registered bitwise logic unit.
// Imported by the function-select mux and the pipeline top.
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSB = 3'b111
    } logic_op_e;

endpackage

// File: rtl/logic_mux8.sv
// Combinational WIDTH-bit 8:1 logic-function select.
// Built from three levels of AND/OR style 2:1 muxes.
module logic_mux8
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] f0, f1, f2, f3, f4, f5, f6, f7;
    logic [WIDTH-1:0] l1_0, l1_1, l1_2, l1_3;
    logic [WIDTH-1:0] l2_0, l2_1;
    logic [WIDTH-1:0] s0, s1, s2;

    assign f0 = opa & opb;
    assign f1 = opa | opb;
    assign f2 = opa ^ opb;
    assign f3 = ~(opa & opb);
    assign f4 = ~(opa | opb);
    assign f5 = ~(opa ^ opb);
    assign f6 = ~opa;
    assign f7 = opb;

    assign s0 = {WIDTH{op[0]}};
    assign s1 = {WIDTH{op[1]}};
    assign s2 = {WIDTH{op[2]}};

    // Each stage: (lo & ~sel) | (hi & sel)
    assign l1_0 = (f0 & ~s0) | (f1 & s0);
    assign l1_1 = (f2 & ~s0) | (f3 & s0);
    assign l1_2 = (f4 & ~s0) | (f5 & s0);
    assign l1_3 = (f6 & ~s0) | (f7 & s0);

    assign l2_0 = (l1_0 & ~s1) | (l1_1 & s1);
    assign l2_1 = (l1_2 & ~s1) | (l1_3 & s1);

    assign y = (l2_0 & ~s2) | (l2_1 & s2);

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with accumulator chaining and a
// one-entry valid/ready output buffer.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] y;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign opa      = acc_en ? acc : a;

    logic_mux8 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .opa(opa),
        .opb(b),
        .op (op),
        .y  (y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= y;
            zero      <= (y == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over the update; the beat itself already used the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe.
// A second instance with CNT_W=2 shares stimulus to check counter wrap.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic [7:0] op_count;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] result2;
    logic       zero2;
    logic [1:0] op_count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .op_count (op_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready2),
        .a        (a),
        .b        (b),
        .op       (op),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .out_valid(out_valid2),
        .out_ready(out_ready),
        .result   (result2),
        .zero     (zero2),
        .op_count (op_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        a = 8'hFF;
        b = 8'hFF;
        op = 3'b001;
        acc_en = 1'b0;
        acc_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, result, zero, op_count, in_ready}
                !== {1'b0, 8'h00, 1'b1, 8'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset: ov=%b res=%h z=%b cnt=%0d ir=%b, want 0 00 1 0 1",
                     out_valid, result, zero, op_count, in_ready);
        end
        step();
        n_cmp++;
        if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL idle: ov=%b ir=%b cnt=%0d, want 0 1 0",
                     out_valid, in_ready, op_count);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hCC};
        a = 8'hF0;
        b = 8'hCC;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = i[2:0];
            step();
            n_cmp++;
            if ({out_valid, result, zero} !== {1'b1, exp_tab[i], 1'b0}) begin
                n_bad++;
                $display("FAIL op_sweep[%0d]: ov=%b res=%h z=%b, want 1 %h 0",
                         i, out_valid, result, zero, exp_tab[i]);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if ({out_valid, op_count} !== {1'b0, 8'd8}) begin
            n_bad++;
            $display("FAIL sweep_count: ov=%b cnt=%0d, want 0 8",
                     out_valid, op_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'h0F;
        b = 8'hFF;
        op = 3'b001;
        step();
        n_cmp++;
        if ({result, out_valid, in_ready} !== {8'hFF, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_load: res=%h ov=%b ir=%b, want ff 1 0",
                     result, out_valid, in_ready);
        end
        b = 8'hF0;
        op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({result, out_valid, in_ready, op_count}
                    !== {8'hFF, 1'b1, 1'b0, 8'd9}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: res=%h ov=%b ir=%b cnt=%0d, want ff 1 0 9",
                         i, result, out_valid, in_ready, op_count);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready: ir=%b, want 1", in_ready);
        end
        step();
        n_cmp++;
        if ({result, zero, out_valid, op_count}
                !== {8'h00, 1'b1, 1'b1, 8'd10}) begin
            n_bad++;
            $display("FAIL bp_release: res=%h z=%b ov=%b cnt=%0d, want 00 1 1 10",
                     result, zero, out_valid, op_count);
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_accumulator();
        logic [7:0] bs  [4];
        logic [7:0] exp_tab [4];
        logic [2:0] ops [4];
        bs = '{8'h01, 8'h02, 8'h04, 8'h07};
        exp_tab = '{8'h01, 8'h03, 8'h07, 8'h00};
        ops = '{3'b001, 3'b001, 3'b001, 3'b010};
        out_ready = 1'b1;
        acc_clr = 1'b1;
        in_valid = 1'b0;
        step();
        acc_clr = 1'b0;
        acc_en = 1'b1;
        a = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = bs[i];
            op = ops[i];
            step();
            n_cmp++;
            if ({result, zero} !== {exp_tab[i], exp_tab[i] == 8'h00}) begin
                n_bad++;
                $display("FAIL acc[%0d]: res=%h z=%b, want %h %b",
                         i, result, zero, exp_tab[i], exp_tab[i] == 8'h00);
            end
        end
        in_valid = 1'b0;
        acc_en = 1'b0;
        step();
    endtask

    task automatic test_clear_collision();
        out_ready = 1'b1;
        in_valid = 1'b1;
        acc_en = 1'b0;
        op = 3'b111;
        b = 8'h3C;
        step();
        // Clear together with a beat that reads the old accumulator.
        acc_en = 1'b1;
        acc_clr = 1'b1;
        op = 3'b000;
        b = 8'hFF;
        step();
        n_cmp++;
        if (result !== 8'h3C) begin
            n_bad++;
            $display("FAIL clr_preval: res=%h, want 3c", result);
        end
        acc_clr = 1'b1;
        op = 3'b111;
        b = 8'h55;
        step();
        n_cmp++;
        if (result !== 8'h55) begin
            n_bad++;
            $display("FAIL clr_passb: res=%h, want 55", result);
        end
        acc_clr = 1'b0;
        op = 3'b110;
        step();
        n_cmp++;
        if ({result, zero} !== {8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL clr_nota: res=%h z=%b, want ff 0", result, zero);
        end
        in_valid = 1'b0;
        acc_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc_en = 1'b0;
        op = 3'b111;
        b = 8'h81;
        step();
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 8'h81}) begin
            n_bad++;
            $display("FAIL mid_load: ov=%b res=%h, want 1 81", out_valid, result);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, op_count, result, zero, op_count2}
                !== {1'b0, 8'd0, 8'h00, 1'b1, 2'd0}) begin
            n_bad++;
            $display("FAIL mid_reset: ov=%b cnt=%0d res=%h z=%b cnt2=%0d, want 0 0 00 1 0",
                     out_valid, op_count, result, zero, op_count2);
        end
        // Accumulator held 0x81 before reset; NOT A of a cleared one is 0xFF.
        in_valid = 1'b1;
        acc_en = 1'b1;
        op = 3'b110;
        step();
        n_cmp++;
        if (result !== 8'hFF) begin
            n_bad++;
            $display("FAIL mid_acc: res=%h, want ff", result);
        end
        in_valid = 1'b0;
        acc_en = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if ({op_count2, op_count} !== {2'd1, 8'd5}) begin
            n_bad++;
            $display("FAIL wrap: cnt2=%0d cnt=%0d, want 1 5", op_count2, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_op_sweep();
        test_backpressure();
        test_accumulator();
        test_clear_collision();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
